// File: rtl/lab6_counter_ctrl.sv
// Start/step/stop sequencer for a falling-edge JK-flip-flop up/down counter bank.
// Exports per-bit J/K excitation so an external JK bank can mirror the count.
module lab6_counter_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             dir,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] step_val;

  assign step_val = dir ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));

  // count_d is the full next value (reset included), so j/k fall out directly
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (!reset_n) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            count_d = load_val;
          end
        end
        RUN: begin
          if (stop) begin
            state_d = IDLE;
          end else if (en) begin
            count_d = step_val;
            if (step_val == limit) state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign j     = count_d & ~count_q;
  assign k     = ~count_d & count_q;
  assign count = count_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule

// File: doc/lab6_counter_ctrl.md
# lab6_counter_ctrl

Sequencing controller for a WIDTH-bit bank of negative-edge JK flip-flops used as a loadable up/down counter. A three-state FSM (IDLE/RUN/DONE) handles start, step, stop and terminal-count detection. It exports the per-bit J/K excitation that moves the bank from its current value to the next value, so an external JK register bank can mirror the internal count exactly. It sits between lab-level control inputs (start/stop/direction) and the flip-flop datapath.

## Interface
- WIDTH, 4, counter / JK bank width in bits (≥2)
- clk  input  1  clock; all state updates on the falling edge
- reset_n  input  1  synchronous, active-low reset, sampled on the falling edge of clk
- start  input  1  begin a count run; honoured only in IDLE
- stop  input  1  abort a run; honoured only in RUN
- en  input  1  step enable in RUN
- dir  input  1  0 = count up, 1 = count down
- load_val  input  WIDTH  initial count loaded on start
- limit  input  WIDTH  terminal value that ends a run
- count  output  WIDTH  current counter value (registered)
- j  output  WIDTH  J excitation for the next edge (combinational)
- k  output  WIDTH  K excitation for the next edge (combinational)
- busy  output  1  high while in RUN
- done  output  1  high for exactly one cycle in DONE

## Operation
- State encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10. Code 2'b11 is illegal and returns to IDLE on the next edge with count unchanged.
- Reset (reset_n=0 at a falling edge): state=IDLE, count=0. Reset overrides all other inputs.
- Resulting reset values: count=0, busy=0, done=0.
- IDLE:
  - count holds.
  - start=1 → count←load_val, state→RUN.
  - stop and en are ignored.
- RUN, priority order:
  - stop=1 → state→IDLE, count holds. stop wins over a step on the same edge.
  - en=0 → hold. No terminal check is made.
  - en=1 → next=count+1 (dir=0) or count−1 (dir=1), modulo 2^WIDTH. Wrap-around is silent.
  - If next==limit, state→DONE on the same edge. Otherwise stay in RUN.
- DONE: count holds and done=1. The next edge always goes to IDLE, regardless of start or stop.
- start is ignored in RUN and DONE.
- load_val==limit: the run is not terminated at load. It ends only when a step lands on limit, i.e. after 2^WIDTH enabled steps.
- Excitation:
  - next_count is the value count will take at the coming edge under all the rules above, including reset (next=0) and hold (next=count).
  - j[i] = next_count[i] & ~count[i]
  - k[i] = ~next_count[i] & count[i]
  - In any hold condition j=k=0.
  - During reset j=0 and k=count.
- Outputs busy and done decode the state register directly; neither is a glitching combinational function of the inputs.

## Timing
- Inputs are sampled on the falling edge of clk. Registered outputs change only after a falling edge. j and k are combinational from count, state and the inputs, and must be stable before the next falling edge.
- start → load: 1 edge. start sampled at edge N gives count=load_val and busy=1 after edge N.
- Step latency: 1 edge per enabled step.
- Terminal: at the edge where count becomes limit, busy falls and done rises together. done falls at the following edge.
- Reset mid-run or in DONE: takes effect at the first edge with reset_n=0. No done pulse is produced.
- Reset released together with start=1: the first edge with reset_n=1 performs the start.

## Test plan
- Reset: reset_n=0 for 2 falling edges with start=1 and en=1 → count=0, busy=0, done=0; j=0000, k=0000 after reset.
- Up run: WIDTH=4, load_val=3, limit=6, dir=0, en=1, start pulse → count goes 3,4,5,6 on successive edges. busy=1 from edge 1; busy=0 and done=1 after edge 4; done=0 after edge 5; count stays 6.
- Down wrap: load_val=1, limit=14, dir=1, en=1 → count goes 1,0,15,14. done pulses once after the step to 14. No early termination at 0.
- Enable gaps and stop: load_val=0, limit=9, up. Two enabled steps (count=2), then en=0 for 3 edges (count stays 2, j=k=0000). Then stop=1 with en=1 → IDLE, count=2, done never asserted.
- Reset mid-run: count=5, busy=1, reset_n=0 for one edge → count=0, IDLE, no done pulse. A start on the following edge loads load_val normally.
- Excitation: count=0111, RUN, dir=0, en=1, limit=1111 → j=1000, k=0111 before the edge; count=1000 after it. An external JK bank driven by j/k matches count on every edge.
